// File: rtl/cache.sv
// Direct-mapped write-through, write-allocate byte cache: 8 lines x 4 bytes, 8-bit address.
// Latency: read hit -> PRead_ready 1 cycle after the request is sampled; misses add the memory fetch time.
// Backpressure: every handshake is level request / registered ready; memory may stall indefinitely by holding ready low.
//
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   PRead_*, PWrite_*  processor byte port (PAddress/PWrite_data latched when the request is accepted)
//   MRead_*, MWrite_*  memory line port (32-bit lines, byte k at [8k+7:8k]); MAddress is line aligned
module cache (
   input  logic        clk,
   input  logic        rst,
   input  logic        PRead_request,
   output logic        PRead_ready,
   output logic [7:0]  PRead_data,
   input  logic [7:0]  PAddress,
   input  logic        PWrite_request,
   output logic        PWrite_ready,
   input  logic [7:0]  PWrite_data,
   output logic        MRead_request,
   input  logic        MRead_ready,
   input  logic [31:0] MRead_data,
   output logic [7:0]  MAddress,
   output logic        MWrite_request,
   input  logic        MWrite_ready,
   output logic [31:0] MWrite_data
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WRITE_MEM,
      READ_DONE,
      WRITE_DONE
   } state_t;

   state_t      state;
   logic [7:0]  valid;
   logic [2:0]  tag_mem  [8];
   logic [31:0] data_mem [8];

   // Request captured at acceptance in IDLE; later PAddress/PWrite_data changes are ignored.
   logic [7:0]  req_addr;
   logic [7:0]  req_wdata;
   logic        req_write;

   logic [2:0]  p_index;
   logic        p_hit;
   logic [31:0] p_merged;
   logic [2:0]  r_index;
   logic [31:0] f_merged;

   function automatic logic [31:0] merge_byte(input logic [31:0] line, input logic [1:0] off,
                                              input logic [7:0] b);
      logic [31:0] r;
      r = line;
      r[{off, 3'b000} +: 8] = b;
      return r;
   endfunction

   function automatic logic [7:0] pick_byte(input logic [31:0] line, input logic [1:0] off);
      return line[{off, 3'b000} +: 8];
   endfunction

   // IDLE looks up the live address; FETCH works from the captured one.
   assign p_index  = PAddress[4:2];
   assign p_hit    = valid[p_index] && (tag_mem[p_index] == PAddress[7:5]);
   assign p_merged = merge_byte(data_mem[p_index], PAddress[1:0], PWrite_data);
   assign r_index  = req_addr[4:2];
   assign f_merged = merge_byte(MRead_data, req_addr[1:0], req_wdata);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         valid          <= '0;
         for (int i = 0; i < 8; i++) begin
            tag_mem[i]  <= '0;
            data_mem[i] <= '0;
         end
         req_addr       <= '0;
         req_wdata      <= '0;
         req_write      <= 1'b0;
         PRead_ready    <= 1'b0;
         PRead_data     <= '0;
         PWrite_ready   <= 1'b0;
         MRead_request  <= 1'b0;
         MWrite_request <= 1'b0;
         MAddress       <= '0;
         MWrite_data    <= '0;
      end else begin
         case (state)
            IDLE: begin
               // Read wins when both requests are raised together.
               if (PRead_request) begin
                  req_addr  <= PAddress;
                  req_write <= 1'b0;
                  if (p_hit) begin
                     PRead_data  <= pick_byte(data_mem[p_index], PAddress[1:0]);
                     PRead_ready <= 1'b1;
                     state       <= READ_DONE;
                  end else begin
                     MAddress      <= {PAddress[7:2], 2'b00};
                     MRead_request <= 1'b1;
                     state         <= FETCH;
                  end
               end else if (PWrite_request) begin
                  req_addr  <= PAddress;
                  req_wdata <= PWrite_data;
                  req_write <= 1'b1;
                  MAddress  <= {PAddress[7:2], 2'b00};
                  if (p_hit) begin
                     data_mem[p_index] <= p_merged;
                     MWrite_data       <= p_merged;
                     MWrite_request    <= 1'b1;
                     state             <= WRITE_MEM;
                  end else begin
                     MRead_request <= 1'b1;
                     state         <= FETCH;
                  end
               end
            end
            FETCH: begin
               if (MRead_ready) begin
                  MRead_request    <= 1'b0;
                  valid[r_index]   <= 1'b1;
                  tag_mem[r_index] <= req_addr[7:5];
                  if (req_write) begin
                     // Allocate then write through: the merged line goes both ways.
                     data_mem[r_index] <= f_merged;
                     MWrite_data       <= f_merged;
                     MWrite_request    <= 1'b1;
                     state             <= WRITE_MEM;
                  end else begin
                     data_mem[r_index] <= MRead_data;
                     PRead_data        <= pick_byte(MRead_data, req_addr[1:0]);
                     PRead_ready       <= 1'b1;
                     state             <= READ_DONE;
                  end
               end
            end
            WRITE_MEM: begin
               if (MWrite_ready) begin
                  MWrite_request <= 1'b0;
                  PWrite_ready   <= 1'b1;
                  state          <= WRITE_DONE;
               end
            end
            READ_DONE: begin
               if (!PRead_request) begin
                  PRead_ready <= 1'b0;
                  state       <= IDLE;
               end
            end
            WRITE_DONE: begin
               if (!PWrite_request) begin
                  PWrite_ready <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cache.sv
// Self-checking bench for cache: byte-memory model plus tag/valid model, directed transactions.
// Latency: memory responder answers after a programmable number of cycles per port.
// Backpressure: responder holds ready low until its latency expires, exercising stalls.
module tb_cache;

   logic        clk;
   logic        rst;
   logic        PRead_request;
   logic        PRead_ready;
   logic [7:0]  PRead_data;
   logic [7:0]  PAddress;
   logic        PWrite_request;
   logic        PWrite_ready;
   logic [7:0]  PWrite_data;
   logic        MRead_request;
   logic        MRead_ready;
   logic [31:0] MRead_data;
   logic [7:0]  MAddress;
   logic        MWrite_request;
   logic        MWrite_ready;
   logic [31:0] MWrite_data;

   cache dut (
      .clk            (clk),
      .rst            (rst),
      .PRead_request  (PRead_request),
      .PRead_ready    (PRead_ready),
      .PRead_data     (PRead_data),
      .PAddress       (PAddress),
      .PWrite_request (PWrite_request),
      .PWrite_ready   (PWrite_ready),
      .PWrite_data    (PWrite_data),
      .MRead_request  (MRead_request),
      .MRead_ready    (MRead_ready),
      .MRead_data     (MRead_data),
      .MAddress       (MAddress),
      .MWrite_request (MWrite_request),
      .MWrite_ready   (MWrite_ready),
      .MWrite_data    (MWrite_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;

   // Model state: memory bytes and which line each cache slot holds.
   logic [7:0]  mem [256];
   bit          mvalid [8];
   logic [2:0]  mtag [8];

   // Expectations published by the transaction tasks for the compare process.
   logic [7:0]  exp_rbyte;
   logic [7:0]  exp_maddr;
   logic [31:0] exp_wline;
   bit          fetch_ok;
   bit          write_ok;
   bit          saw_mread;
   bit          saw_mwrite;
   logic [31:0] last_wline;
   int          rd_lat;
   int          wr_lat;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_outs_zero(input string tag);
      chk({tag, "_flags"}, {28'd0, PRead_ready, PWrite_ready, MRead_request, MWrite_request}, 32'd0);
      chk({tag, "_prdata"}, {24'd0, PRead_data}, 32'd0);
      chk({tag, "_maddr"}, {24'd0, MAddress}, 32'd0);
      chk({tag, "_mwdata"}, MWrite_data, 32'd0);
   endtask

   // Memory responder: serves lines from the byte model, commits accepted writes to it.
   initial begin
      int rd_cnt;
      int wr_cnt;
      int a;
      rd_cnt = 0;
      wr_cnt = 0;
      MRead_ready  = 1'b0;
      MRead_data   = '0;
      MWrite_ready = 1'b0;
      forever begin
         @(negedge clk);
         a = int'(MAddress);
         if (rst && MRead_request) begin
            if (rd_cnt >= rd_lat) begin
               MRead_data  = {mem[a+3], mem[a+2], mem[a+1], mem[a]};
               MRead_ready = 1'b1;
            end else begin
               rd_cnt++;
               MRead_ready = 1'b0;
            end
         end else begin
            MRead_ready = 1'b0;
            rd_cnt      = 0;
         end
         if (rst && MWrite_request) begin
            if (wr_cnt >= wr_lat) begin
               for (int k = 0; k < 4; k++) mem[a+k] = MWrite_data[8*k +: 8];
               MWrite_ready = 1'b1;
            end else begin
               wr_cnt++;
               MWrite_ready = 1'b0;
            end
         end else begin
            MWrite_ready = 1'b0;
            wr_cnt       = 0;
         end
      end
   end

   // Compare process: every cycle, check whatever the DUT is presenting against the model.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            if (MRead_request) begin
               saw_mread = 1'b1;
               chk("mread_allowed", {31'd0, fetch_ok}, 32'd1);
               chk("mread_addr", {24'd0, MAddress}, {24'd0, exp_maddr});
            end
            if (MWrite_request) begin
               saw_mwrite = 1'b1;
               last_wline = MWrite_data;
               chk("mwrite_allowed", {31'd0, write_ok}, 32'd1);
               chk("mwrite_addr", {24'd0, MAddress}, {24'd0, exp_maddr});
               chk("mwrite_line", MWrite_data, exp_wline);
            end
            if (PRead_ready)
               chk("pread_byte", {24'd0, PRead_data}, {24'd0, exp_rbyte});
         end
      end
   end

   task automatic do_read(input logic [7:0] a, input bit exp_hit, input logic [7:0] lit,
                          input bit scramble);
      int  idx;
      int  n;
      bit  mhit;
      idx  = int'(a[4:2]);
      mhit = mvalid[idx] && (mtag[idx] == a[7:5]);
      chk("model_rd_hit", {31'd0, mhit}, {31'd0, exp_hit});
      exp_rbyte = mem[a];
      exp_maddr = {a[7:2], 2'b00};
      fetch_ok  = !mhit;
      write_ok  = 1'b0;
      saw_mread = 1'b0;
      @(negedge clk);
      PAddress      = a;
      PRead_request = 1'b1;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
         if (scramble) PAddress = 8'hFF;
      end while (!PRead_ready && n < 200);
      chk("rd_ready_seen", {31'd0, PRead_ready}, 32'd1);
      chk("rd_data_lit", {24'd0, PRead_data}, {24'd0, lit});
      chk("rd_fetch_seen", {31'd0, saw_mread}, {31'd0, !exp_hit});
      if (exp_hit) chk("rd_hit_latency", n, 32'd1);
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rd_ready_held", {31'd0, PRead_ready}, 32'd1);
      @(negedge clk);
      PRead_request = 1'b0;
      @(posedge clk);
      #1;
      chk("rd_ready_drop", {31'd0, PRead_ready}, 32'd0);
      mvalid[idx] = 1'b1;
      mtag[idx]   = a[7:5];
      fetch_ok    = 1'b0;
   endtask

   task automatic do_write(input logic [7:0] a, input logic [7:0] d, input bit exp_hit,
                           input logic [31:0] lit);
      int          idx;
      int          b;
      int          n;
      bit          mhit;
      logic [31:0] line;
      idx  = int'(a[4:2]);
      b    = int'({a[7:2], 2'b00});
      mhit = mvalid[idx] && (mtag[idx] == a[7:5]);
      chk("model_wr_hit", {31'd0, mhit}, {31'd0, exp_hit});
      line = {mem[b+3], mem[b+2], mem[b+1], mem[b]};
      line[8*int'(a[1:0]) +: 8] = d;
      exp_wline  = line;
      exp_maddr  = {a[7:2], 2'b00};
      fetch_ok   = !mhit;
      write_ok   = 1'b1;
      saw_mread  = 1'b0;
      saw_mwrite = 1'b0;
      last_wline = '0;
      @(negedge clk);
      PAddress       = a;
      PWrite_data    = d;
      PWrite_request = 1'b1;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!PWrite_ready && n < 200);
      chk("wr_ready_seen", {31'd0, PWrite_ready}, 32'd1);
      chk("wr_mwrite_seen", {31'd0, saw_mwrite}, 32'd1);
      chk("wr_line_lit", last_wline, lit);
      chk("wr_fetch_seen", {31'd0, saw_mread}, {31'd0, !exp_hit});
      @(posedge clk);
      #1;
      chk("wr_ready_held", {31'd0, PWrite_ready}, 32'd1);
      @(negedge clk);
      PWrite_request = 1'b0;
      @(posedge clk);
      #1;
      chk("wr_ready_drop", {31'd0, PWrite_ready}, 32'd0);
      mvalid[idx] = 1'b1;
      mtag[idx]   = a[7:5];
      fetch_ok    = 1'b0;
      write_ok    = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      int n;
      for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
      mem[8'h00] = 8'h11; mem[8'h01] = 8'h22; mem[8'h02] = 8'h33; mem[8'h03] = 8'h44;
      mem[8'h24] = 8'h0A; mem[8'h25] = 8'h0B; mem[8'h26] = 8'h0C; mem[8'h27] = 8'h0D;
      for (int i = 0; i < 8; i++) begin
         mvalid[i] = 1'b0;
         mtag[i]   = '0;
      end
      fetch_ok = 1'b0; write_ok = 1'b0; saw_mread = 1'b0; saw_mwrite = 1'b0;
      exp_rbyte = '0; exp_maddr = '0; exp_wline = '0; last_wline = '0;
      rd_lat = 0; wr_lat = 0;
      PRead_request = 1'b0; PWrite_request = 1'b0; PAddress = '0; PWrite_data = '0;

      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_outs_zero("reset");
      @(negedge clk);
      rst = 1'b1;

      do_read(8'h03, 1'b0, 8'h44, 1'b0);            // cold miss, fetch line 0x00
      do_read(8'h02, 1'b1, 8'h33, 1'b0);            // hit in same line
      do_write(8'h02, 8'hAA, 1'b1, 32'h44AA2211);   // write hit, merged line out
      do_read(8'h02, 1'b1, 8'hAA, 1'b0);
      do_write(8'h25, 8'h5C, 1'b0, 32'h0D0C5C0A);   // write miss allocates line 0x24
      do_read(8'h25, 1'b1, 8'h5C, 1'b0);
      do_read(8'h23, 1'b0, 8'h86, 1'b0);            // conflict: index 0, tag 1
      do_read(8'h03, 1'b0, 8'h44, 1'b0);            // line 0x00 was evicted

      // Both requests together: read wins, no memory write happens.
      exp_rbyte = 8'h44; fetch_ok = 1'b0; write_ok = 1'b0; saw_mwrite = 1'b0;
      @(negedge clk);
      PAddress = 8'h03; PWrite_data = 8'h99; PRead_request = 1'b1; PWrite_request = 1'b1;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!PRead_ready && n < 50);
      chk("both_rd_ready", {31'd0, PRead_ready}, 32'd1);
      chk("both_rd_data", {24'd0, PRead_data}, 32'h44);
      chk("both_wr_ready", {31'd0, PWrite_ready}, 32'd0);
      @(negedge clk);
      PRead_request = 1'b0; PWrite_request = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("both_no_mwrite", {31'd0, saw_mwrite}, 32'd0);

      // Slow memory, address scrambled after acceptance.
      rd_lat = 3; wr_lat = 2;
      do_read(8'h47, 1'b0, 8'hE2, 1'b1);
      do_write(8'h46, 8'h77, 1'b1, 32'hE277E0E1);
      rd_lat = 0; wr_lat = 0;
      do_read(8'h25, 1'b0, 8'h5C, 1'b0);            // evicted; memory kept the written byte

      // Reset while a fetch is outstanding.
      rd_lat = 1000; fetch_ok = 1'b1; exp_maddr = 8'h40;
      @(negedge clk);
      PAddress = 8'h43; PRead_request = 1'b1;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!MRead_request && n < 50);
      chk("rst_fetch_seen", {31'd0, MRead_request}, 32'd1);
      #2;
      rst = 1'b0;
      #1;
      chk_outs_zero("midrst");
      PRead_request = 1'b0;
      fetch_ok = 1'b0;
      rd_lat = 0;
      for (int i = 0; i < 8; i++) mvalid[i] = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_no_ready", {31'd0, PRead_ready}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      do_read(8'h03, 1'b0, 8'h44, 1'b0);            // valid bits were cleared

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cache.md
Name: cache

Overview:
- Direct-mapped, write-through, write-allocate byte cache between an 8-bit processor port and a 32-bit line-wide memory port.
- Processor issues byte reads and writes using request/ready handshakes.
- Cache serves read hits locally; it fetches whole 4-byte lines from memory on misses.
- Every write is propagated to memory as a full merged line.

Parameters:
- none. Geometry is fixed: 8 lines × 4 bytes, 8-bit address.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- PRead_request  in  1  processor read request; level, held until PRead_ready is seen
- PRead_ready  out  1  read complete; PRead_data valid while high
- PRead_data  out  8  read byte
- PAddress  in  8  byte address; held stable while a request is high
- PWrite_request  in  1  processor write request; level, held until PWrite_ready
- PWrite_ready  out  1  write complete (line written to memory)
- PWrite_data  in  8  byte to write; held stable with PWrite_request
- MRead_request  out  1  line fetch request to memory
- MRead_ready  in  1  memory read data valid, one-cycle pulse or level
- MRead_data  in  32  fetched line; byte k = MRead_data[8k+7:8k]
- MAddress  out  8  line-aligned memory address: {PAddress[7:2],2'b00}
- MWrite_request  out  1  line write request to memory
- MWrite_ready  in  1  memory write accepted
- MWrite_data  out  32  line written to memory, same byte order as MRead_data

Behaviour:
- Address split: offset = PAddress[1:0]; index = PAddress[4:2]; tag = PAddress[7:5].
- Storage per line: valid bit, 3-bit tag, 32-bit data.
- Hit condition: valid[index] && tag matches.
- Reset (rst=0, asynchronous):
  - All valid bits cleared; FSM forced to IDLE.
  - All outputs 0: PRead_ready, PWrite_ready, PRead_data, MRead_request, MWrite_request, MAddress, MWrite_data.
  - Reset mid-transaction abandons the transaction. Memory requests drop immediately and no ready is issued.
- FSM states: IDLE, FETCH, WRITE_MEM, READ_DONE, WRITE_DONE.
- IDLE:
  - If PRead_request and PWrite_request are both high, read has priority.
  - Read hit: latch byte into PRead_data, go to READ_DONE. PRead_ready rises one cycle after the request is sampled.
  - Read miss or write miss: drive MAddress, assert MRead_request, go to FETCH.
  - Write hit: merge PWrite_data into the line at offset (cache array updated). Load the merged line into MWrite_data, drive MAddress, assert MWrite_request, go to WRITE_MEM.
- FETCH:
  - Hold MRead_request until MRead_ready is sampled high.
  - On MRead_ready: install line (data, tag, valid=1) and drop MRead_request.
  - Pending read: output requested byte on PRead_data, go to READ_DONE.
  - Pending write: merge byte into the installed line, then proceed exactly as a write hit into WRITE_MEM.
- WRITE_MEM: hold MWrite_request, MAddress and MWrite_data until MWrite_ready is sampled high. Then drop MWrite_request and go to WRITE_DONE.
- Memory ready timing: MRead_ready or MWrite_ready arriving in the same cycle the request is first raised is accepted. Ready asserted while no request is pending is ignored.
- READ_DONE / WRITE_DONE:
  - Hold the corresponding ready high, and PRead_data stable, while the request stays high.
  - When the request is sampled low, drop ready and return to IDLE. The next transaction may start in the following cycle.
- Miss replacement: no dirty state (write-through), so replacement simply overwrites the line.
- Cache contents always equal memory contents for valid lines.
- PAddress or PWrite_data changes while a transaction is outside IDLE are ignored. Address and data are latched at acceptance in IDLE.

Test Plan:
- Read miss: reset, then PAddress=0x03, PRead_request=1, respond MRead_data=0x44332211 with MRead_ready pulse → MRead_request=1 with MAddress=0x00, then PRead_ready=1 with PRead_data=0x44, held until request drops.
- Read hit: following the above, PAddress=0x02 read → PRead_ready one cycle later, PRead_data=0x33, MRead_request never asserted.
- Write hit: PAddress=0x02, PWrite_data=0xAA → MWrite_request=1, MAddress=0x00, MWrite_data=0x44AA2211. After MWrite_ready, PWrite_ready=1. A subsequent read of 0x02 hits and returns 0xAA.
- Write miss with allocate: PAddress=0x25, PWrite_data=0x5C, memory returns 0x0D0C0B0A → fetch at MAddress=0x24, then MWrite_data=0x0D0C5C0A. A later read of 0x25 hits with 0x5C.
- Conflict: after line 0 holds tag 0, read PAddress=0x23 (index 0, tag 1) → miss, fetch MAddress=0x20. A subsequent read of 0x03 misses again.
- Reset mid-FETCH: pull rst low while MRead_request=1 → all outputs 0 immediately. After release, read of 0x03 misses (valid cleared).
